// File: rtl/score_pkg.sv
// Shared types and constants for the score tick counter.
// Holds the control state enum, BCD digit constants and the next-state helper.
package score_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    HALT   = 2'd3
  } state_t;

  // Priority: clr > game_over > pause > start.
  function automatic state_t next_state(
    input state_t s,
    input logic   clr,
    input logic   game_over,
    input logic   pause,
    input logic   start
  );
    state_t n;
    n = s;
    unique case (s)
      IDLE:   if (start && !pause) n = RUN;
      RUN: begin
        if (game_over)  n = HALT;
        else if (pause) n = PAUSED;
      end
      PAUSED: begin
        if (game_over)   n = HALT;
        else if (!pause) n = RUN;
      end
      HALT:   n = HALT;
      default: n = IDLE;
    endcase
    if (clr) n = IDLE;
    return n;
  endfunction

endpackage

// File: rtl/score_bcd_digit.sv
// One BCD digit of the score with carry to the next digit.
// Ports: clk, rst (async low), inc_in, clr (sync), value[3:0], carry_out.
module score_bcd_digit
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_in,
  input  logic               clr,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out
);

  assign carry_out = inc_in && (value == BCD_DIGIT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc_in) begin
      value <= carry_out ? '0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/score_tick_counter.sv
// Syncs the slow tick clock into clk_50m and counts it into a BCD score.
// Ports: clk_50m, rst (async low), tick_in, start, pause, game_over, clr,
// score_bcd, score_inc, running, halted, max_flag.
// Option: define SCORE_SAT_EN to saturate at all-9s instead of wrapping.
module score_tick_counter
  import score_pkg::*;
#(
  parameter int DIGITS          = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int TICKS_PER_POINT = 1
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  game_over,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  score_inc,
  output logic                  running,
  output logic                  halted,
  output logic                  max_flag
);

  localparam logic [7:0] TPP_LAST = 8'(TICKS_PER_POINT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick_pulse;
  logic [7:0]             presc;
  state_t                 state_q;
  state_t                 state_nx;

  logic                   count_en;
  logic                   due;
  logic                   inc_en;
  logic                   upper9;
  logic                   becomes9;
  logic                   set_max;

  logic [DIGIT_W-1:0]     digit [DIGITS];
  logic [DIGITS-1:0]      inc_chain;
  logic [DIGITS-1:0]      carry;

  // tick_pulse is registered so it lands SYNC_STAGES+1 edges after tick_in.
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      tick_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_in};
      prev_q     <= sync_q[SYNC_STAGES-1];
      tick_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign state_nx = next_state(state_q, clr, game_over, pause, start);

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_nx;
      running <= (state_nx == RUN);
      halted  <= (state_nx == HALT);
    end
  end

  // Ticks coinciding with any control change are dropped.
  assign count_en = (state_q == RUN) && tick_pulse &&
                    !clr && !game_over && !pause;
  assign due      = count_en && (presc == TPP_LAST);

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (count_en) begin
      presc <= (presc == TPP_LAST) ? 8'd0 : presc + 8'd1;
    end
  end

  always_comb begin
    upper9 = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      if (digit[i] != BCD_DIGIT_MAX) upper9 = 1'b0;
    end
  end

`ifdef SCORE_SAT_EN
  logic all9;
  assign all9     = upper9 && (digit[0] == BCD_DIGIT_MAX);
  assign inc_en   = due && !all9;
  assign becomes9 = inc_en && upper9 &&
                    (digit[0] == BCD_DIGIT_MAX - 4'd1);
  assign set_max  = becomes9 || (due && all9) || carry[DIGITS-1];
`else
  assign inc_en   = due;
  assign becomes9 = inc_en && upper9 &&
                    (digit[0] == BCD_DIGIT_MAX - 4'd1);
  // Carry out of the top digit means the score just wrapped.
  assign set_max  = becomes9 || carry[DIGITS-1];
`endif

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      if (g == 0) begin : g_lsd
        assign inc_chain[g] = inc_en;
      end else begin : g_up
        assign inc_chain[g] = carry[g-1];
      end
      score_bcd_digit u_dig (
        .clk       (clk_50m),
        .rst       (rst),
        .inc_in    (inc_chain[g]),
        .clr       (clr),
        .value     (digit[g]),
        .carry_out (carry[g])
      );
      assign score_bcd[4*g +: 4] = digit[g];
    end
  endgenerate

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      score_inc <= 1'b0;
      max_flag  <= 1'b0;
    end else if (clr) begin
      score_inc <= 1'b0;
      max_flag  <= 1'b0;
    end else begin
      score_inc <= inc_en;
      max_flag  <= max_flag | set_max;
    end
  end

endmodule

// File: tb/tb_score_tick_counter.sv
// Self-checking bench for score_tick_counter (two prescaler settings).
// A cycle model tracks score, prescaler and state for both instances.
module tb_score_tick_counter;

  localparam int S    = 2;
  localparam int MAXV = 999;

  logic clk_50m = 1'b0;
  logic rst, tick_in, start, pause, game_over, clr;

  logic [11:0] sc   [2];
  logic        inc  [2];
  logic        run  [2];
  logic        halt [2];
  logic        mx   [2];

  int errors = 0;
  int checks = 0;
  int inc_cnt = 0;

  int tpp [2] = '{1, 4};
  int ms  [2];
  int msc [2];
  int mpr [2];
  int mm  [2];
  int mi  [2];
  logic [S+1:0] h;

  always #5 clk_50m = ~clk_50m;

  score_tick_counter #(.DIGITS(3), .SYNC_STAGES(S), .TICKS_PER_POINT(1)) dut (
    .clk_50m(clk_50m), .rst(rst), .tick_in(tick_in), .start(start),
    .pause(pause), .game_over(game_over), .clr(clr),
    .score_bcd(sc[0]), .score_inc(inc[0]), .running(run[0]),
    .halted(halt[0]), .max_flag(mx[0])
  );

  score_tick_counter #(.DIGITS(3), .SYNC_STAGES(S), .TICKS_PER_POINT(4)) dut4 (
    .clk_50m(clk_50m), .rst(rst), .tick_in(tick_in), .start(start),
    .pause(pause), .game_over(game_over), .clr(clr),
    .score_bcd(sc[1]), .score_inc(inc[1]), .running(run[1]),
    .halted(halt[1]), .max_flag(mx[1])
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a tick_in rise sampled at edge k is counted at edge k+S+1.
  initial forever begin
    logic pulse;
    @(posedge clk_50m or negedge rst);
    if (!rst) begin
      h = '0;
      for (int m = 0; m < 2; m++) begin
        ms[m] = 0; msc[m] = 0; mpr[m] = 0; mm[m] = 0; mi[m] = 0;
      end
    end else begin
      pulse = h[S] & ~h[S+1];
      for (int m = 0; m < 2; m++) begin
        mi[m] = 0;
        if (clr) begin
          ms[m] = 0; msc[m] = 0; mpr[m] = 0; mm[m] = 0;
        end else begin
          if (ms[m] == 1 && pulse && !game_over && !pause) begin
            mpr[m]++;
            if (mpr[m] == tpp[m]) begin
              mpr[m] = 0;
              if (msc[m] == MAXV) begin
`ifdef SCORE_SAT_EN
                mm[m] = 1;
`else
                msc[m] = 0; mi[m] = 1; mm[m] = 1;
`endif
              end else begin
                msc[m]++; mi[m] = 1;
                if (msc[m] == MAXV) mm[m] = 1;
              end
            end
          end
          case (ms[m])
            0: if (start && !pause) ms[m] = 1;
            1: if (game_over) ms[m] = 3; else if (pause) ms[m] = 2;
            2: if (game_over) ms[m] = 3; else if (!pause) ms[m] = 1;
            default: ;
          endcase
        end
      end
      h = {h[S:0], tick_in};
    end
  end

  initial forever begin
    @(negedge clk_50m);
    if (rst === 1'b1) begin
      if (inc[0]) inc_cnt++;
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d_score", m), 32'(sc[m]), 32'(to_bcd(msc[m])));
        chk($sformatf("m%0d_inc", m), 32'(inc[m]), 32'(mi[m]));
        chk($sformatf("m%0d_run", m), 32'(run[m]), 32'(ms[m] == 1));
        chk($sformatf("m%0d_halt", m), 32'(halt[m]), 32'(ms[m] == 3));
        chk($sformatf("m%0d_max", m), 32'(mx[m]), 32'(mm[m]));
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      repeat (3) @(negedge clk_50m);
      tick_in = 1'b0;
      repeat (3) @(negedge clk_50m);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk_50m);
    clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    @(negedge clk_50m);
  endtask

  initial begin
    int c0;
    rst = 1'b0; tick_in = 1'b0; start = 1'b0;
    pause = 1'b0; game_over = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk_50m);
    chk("rst_score", 32'(sc[0]), 32'h000);
    chk("rst_run", 32'(run[0]), 0);
    chk("rst_halt", 32'(halt[0]), 0);
    chk("rst_max", 32'(mx[0]), 0);
    chk("rst_inc", 32'(inc[0]), 0);
    rst = 1'b1;
    @(negedge clk_50m);

    do_start();
    chk("t1_run", 32'(run[0]), 1);
    c0 = inc_cnt;
    for (int i = 0; i < 5; i++) begin
      tick_in = 1'b1;
      repeat (S + 1) @(negedge clk_50m);
      chk("t1_lat_early", 32'(inc[0]), 0);
      @(negedge clk_50m);
      chk("t1_lat_hit", 32'(inc[0]), 1);
      tick_in = 1'b0;
      repeat (14) @(negedge clk_50m);
    end
    chk("t1_score", 32'(sc[0]), 32'h005);
    chk("t1_incs", 32'(inc_cnt - c0), 5);
    chk("t1_score4", 32'(sc[1]), 32'h001);

    do_clr();
    do_start();
    tick(10);
    chk("t2_score4", 32'(sc[1]), 32'h002);
    pause = 1'b1;
    @(negedge clk_50m);
    chk("t2_paused_run", 32'(run[0]), 0);
    tick(3);
    pause = 1'b0;
    @(negedge clk_50m);
    tick(2);
    chk("t2_score4_end", 32'(sc[1]), 32'h003);
    chk("t2_score1_end", 32'(sc[0]), 32'h012);

    do_clr();
    do_start();
    tick(999);
    chk("t3_999", 32'(sc[0]), 32'h999);
    chk("t3_max_at_999", 32'(mx[0]), 1);
    chk("t3_score4", 32'(sc[1]), 32'h249);
    c0 = inc_cnt;
    tick(1);
`ifdef SCORE_SAT_EN
    chk("t3_sat_score", 32'(sc[0]), 32'h999);
    chk("t3_sat_incs", 32'(inc_cnt - c0), 0);
`else
    chk("t3_wrap_score", 32'(sc[0]), 32'h000);
    chk("t3_wrap_incs", 32'(inc_cnt - c0), 1);
`endif
    chk("t3_max", 32'(mx[0]), 1);
    chk("t3_score4_end", 32'(sc[1]), 32'h250);

    do_clr();
    do_start();
    tick(42);
    chk("t4_042", 32'(sc[0]), 32'h042);
    tick_in = 1'b1;
    repeat (S + 1) @(negedge clk_50m);
    game_over = 1'b1;
    @(negedge clk_50m);
    game_over = 1'b0;
    chk("t4_halted", 32'(halt[0]), 1);
    chk("t4_hold", 32'(sc[0]), 32'h042);
    tick_in = 1'b0;
    repeat (3) @(negedge clk_50m);
    tick(3);
    chk("t4_ignored", 32'(sc[0]), 32'h042);
    do_clr();
    chk("t4_clr_score", 32'(sc[0]), 32'h000);
    chk("t4_clr_max", 32'(mx[0]), 0);
    chk("t4_clr_halt", 32'(halt[0]), 0);

    start = 1'b1; clr = 1'b1;
    @(negedge clk_50m);
    start = 1'b0; clr = 1'b0;
    chk("t5_idle", 32'(run[0]), 0);
    do_start();
    tick(3);
    chk("t5_003", 32'(sc[0]), 32'h003);
    clr = 1'b1; game_over = 1'b1;
    @(negedge clk_50m);
    clr = 1'b0; game_over = 1'b0;
    chk("t5_run", 32'(run[0]), 0);
    chk("t5_halt", 32'(halt[0]), 0);
    chk("t5_score", 32'(sc[0]), 32'h000);

    do_start();
    tick(123);
    chk("t6_123", 32'(sc[0]), 32'h123);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_score", 32'(sc[0]), 32'h000);
    chk("t6_async_run", 32'(run[0]), 0);
    chk("t6_async_score4", 32'(sc[1]), 32'h000);
    @(negedge clk_50m);
    rst = 1'b1;
    repeat (4) @(negedge clk_50m);
    tick(3);
    chk("t6_no_start", 32'(sc[0]), 32'h000);
    do_start();
    tick(2);
    chk("t6_resume", 32'(sc[0]), 32'h002);

    repeat (5) @(negedge clk_50m);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_tick_counter.md
Name: score_tick_counter

Overview:
- Consumer end of the slow game clocks: samples a divided tick clock (the 8 Hz / score clock) in the clk_50m domain and converts it into a clock-enable pulse.
- Uses that pulse to advance a BCD floor/score counter, with start, pause, game-over and clear control.
- Sits between the frequency divider and the score display / game-over logic, so all score state lives in the single clk_50m domain.

Parameters:
- DIGITS, 3, number of BCD digits in the score (max value 10^DIGITS-1).
- SYNC_STAGES, 2, synchronizer flops on tick_in (minimum 2).
- TICKS_PER_POINT, 1, tick rising edges required per score increment (1..255).

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous active-low reset.
- tick_in  in  1  divided tick clock from the divider; asynchronous to clk_50m.
- start  in  1  level; begins counting from IDLE.
- pause  in  1  level; freezes counting while high.
- game_over  in  1  pulse or level; stops counting permanently until clr.
- clr  in  1  synchronous clear to IDLE with score 0.
- score_bcd  out  4*DIGITS  packed BCD score, digit 0 in bits [3:0].
- score_inc  out  1  one-cycle pulse in the cycle score_bcd changes.
- running  out  1  high in RUN state.
- halted  out  1  high in HALT state.
- max_flag  out  1  score has reached all-9s.

Behaviour:
- Reset (rst=0, async): state IDLE, sync flops 0, edge-detect register 0, prescaler 0, score_bcd 0, score_inc 0, running 0, halted 0, max_flag 0.
- Tick sync: tick_in passes through SYNC_STAGES flops. A rising edge of the last stage yields tick_pulse, internal and one cycle wide.
- Latency: tick_in rise to tick_pulse is SYNC_STAGES+1 clk_50m edges. tick_pulse to score_bcd update is 1 edge, with score_inc high in that same cycle.
- States: IDLE, RUN, PAUSED, HALT.
- Transition priority per cycle: clr > game_over > pause > start.
- IDLE to RUN when start=1.
- RUN to PAUSED when pause=1. PAUSED to RUN when pause=0.
- RUN or PAUSED to HALT when game_over=1.
- Any state to IDLE when clr=1. This zeroes score_bcd, prescaler and max_flag. The sync chain is not cleared.
- game_over in IDLE is ignored. start outside IDLE is ignored.
- Counting happens only in RUN. Each tick_pulse increments the prescaler. When the prescaler equals TICKS_PER_POINT-1, it returns to 0 and the score increments.
- Discarded ticks:
  - tick_pulse in IDLE, PAUSED or HALT is discarded and the prescaler holds.
  - tick_pulse coinciding with game_over, pause rising or clr is discarded.
  - tick_pulse in the cycle of the IDLE-to-RUN transition is discarded.
- BCD increment: digit 0 +1. A digit at 9 becomes 0 and carries to the next digit, all in one cycle.
- Overflow (score all 9s and increment due):
  - Default: wraps to all zeros, score_inc=1, max_flag=1 and sticky until clr/reset.
  - max_flag also asserts in the cycle score first becomes all-9s.
- running = (state==RUN). halted = (state==HALT). Both are registered from state, with no extra delay.
- Reset mid-operation: immediate async return to reset values. A tick edge arriving within SYNC_STAGES cycles after reset release may be lost.

Optional Feature:
- SCORE_SAT_EN defined: at all-9s the score holds (saturates), score_inc stays 0 on further due increments, and max_flag=1.
- SCORE_SAT_EN undefined: wrap-to-zero behaviour as above.

Decomposition:
- Shared package score_pkg:
  - state enum (IDLE, RUN, PAUSED, HALT).
  - BCD_DIGIT_MAX=4'd9.
  - DIGIT_W=4.
- One natural sub-module: score_bcd_digit, a single BCD digit with inc_in, clr, value[3:0] and carry_out. It is instantiated DIGITS times in a carry chain.
- Synchronizer and edge detect stay inline.

Test Plan:
- Reset, start=1, 5 tick_in rising edges spaced 1000 cycles -> score_bcd=0x005, five score_inc pulses, each SYNC_STAGES+2 cycles after its tick_in rise.
- TICKS_PER_POINT=4, RUN, 10 ticks -> score_bcd=0x002, prescaler=2; then pause=1, 3 ticks, pause=0, 2 ticks -> score_bcd=0x003.
- Preload to 0x999 by 999 ticks, 1 more tick -> default: 0x000, max_flag=1, score_inc pulse; SCORE_SAT_EN: 0x999 held, no score_inc.
- RUN at 0x042, game_over=1 in the same cycle as a tick_pulse -> halted=1, score stays 0x042; further ticks ignored; clr -> IDLE, 0x000, max_flag=0.
- start and clr asserted together in IDLE -> stays IDLE; clr and game_over together in RUN -> IDLE, score 0.
- rst low mid-RUN at 0x123 -> all outputs 0 asynchronously (before next clk edge); after release, start needed before counting resumes.
